// File: rtl/mshr_hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller: FSM states, MSHR entry
// layout and the hardwired-zero register index.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } mshr_entry_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/mshr_hazard_ctrl_free_enc.sv
// Lowest-index free-entry priority encoder for the MSHR table.
// id is 0 and ready is low when every entry is busy.
module mshr_free_enc #(
    parameter int NUM  = 4,
    parameter int ID_W = $clog2(NUM)
) (
    input  logic [NUM-1:0]  busy,
    output logic [ID_W-1:0] id,
    output logic            ready
);

    always_comb begin
        id    = '0;
        ready = 1'b0;
        for (int unsigned i = 0; i < NUM; i++) begin
            if (!busy[i] && !ready) begin
                id    = ID_W'(i);
                ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mshr_hazard_ctrl.sv
// Execute-stage hazard controller: MSHR scoreboard of outstanding load misses,
// dependency/full stall generation and timed flush pulses on mem-stage redirects.
module mshr_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_MSHR  = 4,
    parameter int ID_W      = $clog2(NUM_MSHR),
    parameter int FLUSH_LEN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [4:0]          ex_reg1,
    input  logic [4:0]          ex_reg2,
    input  logic                ex_use1,
    input  logic                ex_use2,
    input  logic [4:0]          ex_regD,
    input  logic                ex_regwrite,
    input  logic                miss_alloc,
    input  logic [4:0]          miss_rd,
    output logic                alloc_ready,
    output logic [ID_W-1:0]     alloc_id,
    input  logic                fill_valid,
    input  logic [ID_W-1:0]     fill_id,
    input  logic                redirect_branch,
    input  logic                redirect_jump,
    output logic                stall,
    output logic                branch_flush,
    output logic                jal_flush,
    output logic [NUM_MSHR-1:0] mshr_busy,
    output logic [31:0]         stall_cycles,
    output logic                protocol_err
);

    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_LEN - 1);

    mshr_entry_t         tbl [NUM_MSHR];
    logic [NUM_MSHR-1:0] valid_vec;
    logic                alloc_fire;
    logic                fill_hit;
    logic                dep_any;
    logic                dep;
    logic                full;
    logic                redirect;
    state_t              state;
    logic [2:0]          cnt;
    logic                kind_jump;

    function automatic logic reg_hit(
        input logic [4:0] rd,
        input logic [4:0] r1, input logic u1,
        input logic [4:0] r2, input logic u2,
        input logic [4:0] rdx, input logic w
    );
        return (rd != REG_X0) &&
               ((u1 && r1 == rd) || (u2 && r2 == rd) || (w && rdx == rd));
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_MSHR; i++) valid_vec[i] = tbl[i].valid;
    end

    assign mshr_busy = valid_vec;

    mshr_free_enc #(
        .NUM  (NUM_MSHR),
        .ID_W (ID_W)
    ) u_free_enc (
        .busy  (valid_vec),
        .id    (alloc_id),
        .ready (alloc_ready)
    );

    assign alloc_fire = miss_alloc && alloc_ready;
    assign fill_hit   = fill_valid && valid_vec[fill_id];
    assign full       = miss_alloc && !alloc_ready;
    assign redirect   = redirect_branch | redirect_jump;

    // Entry being filled this cycle is excluded: execute forwards its data from WB.
    always_comb begin
        dep_any = 1'b0;
        for (int unsigned i = 0; i < NUM_MSHR; i++) begin
            if (tbl[i].valid && !(fill_valid && fill_id == ID_W'(i)) &&
                reg_hit(tbl[i].rd, ex_reg1, ex_use1, ex_reg2, ex_use2, ex_regD, ex_regwrite))
                dep_any = 1'b1;
        end
        if (alloc_fire &&
            reg_hit(miss_rd, ex_reg1, ex_use1, ex_reg2, ex_use2, ex_regD, ex_regwrite))
            dep_any = 1'b1;
    end

    assign dep          = ex_valid && dep_any;
    assign stall        = (state == RUN) && !redirect && (dep || full);
    assign branch_flush = (state == FLUSH) && !kind_jump;
    assign jal_flush    = (state == FLUSH) && kind_jump;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_MSHR; i++) tbl[i] <= '0;
        end else begin
            if (fill_hit) tbl[fill_id].valid <= 1'b0;
            if (alloc_fire) tbl[alloc_id] <= '{valid: 1'b1, rd: miss_rd};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            kind_jump <= 1'b0;
        end else if (redirect) begin
            state     <= FLUSH;
            cnt       <= FLUSH_CNT;
            kind_jump <= redirect_jump;
        end else if (state == FLUSH) begin
            if (cnt == '0) state <= RUN;
            else           cnt   <= cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (fill_valid && !valid_vec[fill_id]) protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mshr_hazard_ctrl.sv
// Scoreboard bench for mshr_hazard_ctrl: expectations are queued with each
// stimulus step, paired with sampled DUT values and compared per scenario.
module tb_mshr_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_use1, ex_use2, ex_regwrite;
    logic [4:0]  ex_reg1, ex_reg2, ex_regD, miss_rd;
    logic        miss_alloc, fill_valid, redirect_branch, redirect_jump;
    logic [1:0]  fill_id;
    logic        alloc_ready, stall, branch_flush, jal_flush, protocol_err;
    logic [1:0]  alloc_id;
    logic [3:0]  mshr_busy;
    logic [31:0] stall_cycles;

    typedef struct {
        string       name;
        logic [31:0] val;
        logic [31:0] got;
    } exp_t;

    exp_t exp_q[$];
    int   n_snapped = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    mshr_hazard_ctrl #(
        .NUM_MSHR  (4),
        .FLUSH_LEN (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid        (ex_valid),
        .ex_reg1         (ex_reg1),
        .ex_reg2         (ex_reg2),
        .ex_use1         (ex_use1),
        .ex_use2         (ex_use2),
        .ex_regD         (ex_regD),
        .ex_regwrite     (ex_regwrite),
        .miss_alloc      (miss_alloc),
        .miss_rd         (miss_rd),
        .alloc_ready     (alloc_ready),
        .alloc_id        (alloc_id),
        .fill_valid      (fill_valid),
        .fill_id         (fill_id),
        .redirect_branch (redirect_branch),
        .redirect_jump   (redirect_jump),
        .stall           (stall),
        .branch_flush    (branch_flush),
        .jal_flush       (jal_flush),
        .mshr_busy       (mshr_busy),
        .stall_cycles    (stall_cycles),
        .protocol_err    (protocol_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] observe(input string n);
        case (n)
            "stall":  return 32'(stall);
            "bflush": return 32'(branch_flush);
            "jflush": return 32'(jal_flush);
            "busy":   return 32'(mshr_busy);
            "ready":  return 32'(alloc_ready);
            "id":     return 32'(alloc_id);
            "cycles": return stall_cycles;
            "perr":   return 32'(protocol_err);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        e.got  = 'x;
        exp_q.push_back(e);
    endtask

    task automatic snap();
        for (int i = n_snapped; i < exp_q.size(); i++) exp_q[i].got = observe(exp_q[i].name);
        n_snapped = exp_q.size();
    endtask

    task automatic idle();
        ex_valid = 0; ex_use1 = 0; ex_use2 = 0; ex_regwrite = 0;
        ex_reg1 = 0; ex_reg2 = 0; ex_regD = 0;
        miss_alloc = 0; miss_rd = 0; fill_valid = 0; fill_id = 0;
        redirect_branch = 0; redirect_jump = 0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0;
        #1;
        push("busy", 0); push("ready", 1); push("id", 0); push("stall", 0);
        push("bflush", 0); push("jflush", 0); push("cycles", 0); push("perr", 0);
        snap();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_chk++;
            if (e.got !== e.val) begin n_fail++; $display("FAIL reset.%s got=%0h exp=%0h", e.name, e.got, e.val); end
        end
        n_snapped = 0;
    endtask

    task automatic test_dep_fill();
        exp_t e;
        tick(); miss_alloc = 1; miss_rd = 5; #1;
        push("id", 0); push("ready", 1); snap();
        tick(); miss_alloc = 0; ex_valid = 1; ex_reg1 = 5; ex_use1 = 1; #1;
        push("busy", 1); push("stall", 1); push("cycles", 0); snap();
        tick(); #1;
        push("stall", 1); push("cycles", 1); snap();
        tick(); fill_valid = 1; fill_id = 0; #1;
        push("stall", 0); push("busy", 1); push("cycles", 2); snap();
        tick(); fill_valid = 0; #1;
        push("busy", 0); push("stall", 0); push("cycles", 2); snap();
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_chk++;
            if (e.got !== e.val) begin n_fail++; $display("FAIL dep_fill.%s got=%0h exp=%0h", e.name, e.got, e.val); end
        end
        n_snapped = 0;
    endtask

    task automatic test_bypass();
        exp_t e;
        tick(); ex_valid = 1; ex_reg2 = 7; ex_use2 = 1; miss_alloc = 1; miss_rd = 7; #1;
        push("stall", 1); push("id", 0); snap();
        ex_use2 = 0; #1;
        push("stall", 0); snap();
        tick(); miss_alloc = 0; #1;
        push("busy", 1); push("stall", 0); snap();
        ex_regwrite = 1; ex_regD = 7; #1;
        push("stall", 1); snap();
        tick(); idle(); fill_valid = 1; fill_id = 0; #1;
        push("stall", 0); snap();
        tick(); fill_valid = 0; #1;
        push("busy", 0); snap();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_chk++;
            if (e.got !== e.val) begin n_fail++; $display("FAIL bypass.%s got=%0h exp=%0h", e.name, e.got, e.val); end
        end
        n_snapped = 0;
    endtask

    task automatic test_full();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            tick(); idle(); miss_alloc = 1; miss_rd = 5'(i + 1); #1;
            push("id", 32'(i)); push("ready", 1); snap();
        end
        tick(); miss_rd = 9; #1;
        push("busy", 4'hF); push("ready", 0); push("id", 0); push("stall", 1); snap();
        tick(); miss_alloc = 0; fill_valid = 1; fill_id = 2; #1;
        push("perr", 0); snap();
        tick(); fill_valid = 0; #1;
        push("busy", 4'hB); push("ready", 1); push("id", 2); snap();
        miss_alloc = 1; miss_rd = 9;
        tick(); miss_alloc = 0; #1;
        push("busy", 4'hF); push("perr", 0); snap();
        for (int i = 0; i < 4; i++) begin
            tick(); fill_valid = 1; fill_id = 2'(i);
        end
        tick(); idle(); #1;
        push("busy", 0); snap();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_chk++;
            if (e.got !== e.val) begin n_fail++; $display("FAIL full.%s got=%0h exp=%0h", e.name, e.got, e.val); end
        end
        n_snapped = 0;
    endtask

    task automatic test_flush();
        exp_t e;
        tick(); idle(); miss_alloc = 1; miss_rd = 6;
        tick(); miss_alloc = 0; ex_valid = 1; ex_use1 = 1; ex_reg1 = 6; #1;
        push("stall", 1); snap();
        tick(); redirect_branch = 1; #1;
        push("stall", 0); push("bflush", 0); snap();
        tick(); redirect_branch = 0; #1;
        push("bflush", 1); push("jflush", 0); push("stall", 0); snap();
        tick(); #1;
        push("bflush", 1); push("stall", 0); snap();
        tick(); #1;
        push("bflush", 0); push("stall", 1); snap();
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_chk++;
            if (e.got !== e.val) begin n_fail++; $display("FAIL flush.%s got=%0h exp=%0h", e.name, e.got, e.val); end
        end
        n_snapped = 0;
    endtask

    task automatic test_jump_perr();
        exp_t e;
        tick(); redirect_branch = 1; redirect_jump = 1; #1;
        push("stall", 0); snap();
        tick(); redirect_branch = 0; redirect_jump = 0; #1;
        push("jflush", 1); push("bflush", 0); snap();
        tick(); #1;
        push("jflush", 1); push("bflush", 0); snap();
        tick(); #1;
        push("jflush", 0); push("bflush", 0); snap();
        tick(); fill_valid = 1; fill_id = 3; #1;
        push("perr", 0); snap();
        tick(); fill_valid = 0; #1;
        push("perr", 1); push("busy", 1); snap();
        tick(); tick(); #1;
        push("perr", 1); snap();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_chk++;
            if (e.got !== e.val) begin n_fail++; $display("FAIL jump_perr.%s got=%0h exp=%0h", e.name, e.got, e.val); end
        end
        n_snapped = 0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        tick(); miss_alloc = 1; miss_rd = 10; #1;
        push("id", 1); snap();
        tick(); miss_rd = 11; #1;
        push("id", 2); snap();
        tick(); miss_alloc = 0; ex_valid = 1; ex_use1 = 1; ex_reg1 = 10; #1;
        push("busy", 7); push("stall", 1); snap();
        tick(); #3; rst = 1; #1;
        push("busy", 0); push("stall", 0); push("cycles", 0); push("perr", 0);
        push("bflush", 0); push("jflush", 0); push("ready", 1); snap();
        tick(); rst = 0; idle();
        miss_alloc = 1; miss_rd = 0; ex_valid = 1; ex_regwrite = 1; ex_regD = 0; #1;
        push("stall", 0); push("id", 0); snap();
        tick(); miss_alloc = 0; #1;
        push("busy", 1); push("stall", 0); snap();
        tick(); idle(); fill_valid = 1; fill_id = 2;
        tick(); fill_valid = 0; #1;
        push("perr", 1); snap();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_chk++;
            if (e.got !== e.val) begin n_fail++; $display("FAIL reset_mid.%s got=%0h exp=%0h", e.name, e.got, e.val); end
        end
        n_snapped = 0;
    endtask

    initial begin
        test_reset();
        test_dep_fill();
        test_bypass();
        test_full();
        test_flush();
        test_jump_perr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
